uart_program_loader: RTL and testbench
======================================

# uart_program_loader

Serial boot loader upstream of instruction fetch: receives a program image over a UART line, writes it word by word into the instruction memory's write port, and holds the CPU while doing so. On completion it pulses a CPU reset so fetch restarts at PC 0 with the new image. It sits between the board RX pin and the instruction memory (port B write side), alongside the fetch stage that reads port A.

## Interface
- `CLK_FREQ`, default 23_000_000 — clock frequency in Hz.
- `BAUD`, default 128_000 — line rate; `CLKS_PER_BIT = CLK_FREQ/BAUD` (integer division, must be ≥ 4).
- `ADDR_W`, default 14 — instruction memory word-address width.
- `clock`  in  1  — system clock, all logic on posedge.
- `reset`  in  1  — synchronous, active-high.
- `start`  in  1  — one-cycle request to begin a load; ignored unless in IDLE, DONE or ERR.
- `rx`  in  1  — asynchronous UART line, idle high, 8N1, LSB first.
- `imem_we`  out  1  — write strobe, one cycle per word.
- `imem_addr`  out  ADDR_W  — word address (byte address / 4).
- `imem_wdata`  out  32  — instruction word.
- `cpu_hold`  out  1  — CPU must not fetch/commit while high.
- `cpu_reset`  out  1  — one-cycle pulse releasing CPU to PC 0.
- `done`  out  1  — sticky: last load completed.
- `error`  out  1  — sticky: last load aborted.

## Operation
- Frame: 2-byte header N (word count, big-endian, high byte first), then N words, 4 bytes each, big-endian (first byte = bits 31:24). Words go to addresses 0..N-1.
- Valid N: 1 ≤ N ≤ 2^ADDR_W. N = 0 or N > 2^ADDR_W → ERR immediately after header low byte.
- FSM states: IDLE, HDR_HI, HDR_LO, DATA, DONE, ERR.
  - IDLE/DONE/ERR + `start` → HDR_HI; clears `done`, `error`, byte counter, word counter; asserts `cpu_hold`.
  - HDR_HI + byte → HDR_LO; HDR_LO + byte → DATA (or ERR).
  - DATA: shift byte into word register; on 4th byte issue write, increment word counter; after write of word N-1 → DONE.
  - Entering DONE: `cpu_hold` falls, `cpu_reset` pulses for exactly one cycle, `done`=1.
  - Entering ERR: `cpu_hold` stays high, `error`=1, no further writes; only `start` or `reset` leaves.
- UART framing error (stop bit sampled low) in any load state → ERR; byte discarded.
- Bytes arriving in IDLE/DONE/ERR are discarded.
- Word counter is ADDR_W+1 bits so N = 2^ADDR_W is reachable without wrap.

## Timing
- Reset values: `imem_we`=0, `imem_addr`=0, `imem_wdata`=0, `cpu_hold`=0, `cpu_reset`=0, `done`=0, `error`=0, FSM=IDLE, receiver idle.
- `rx` passes a 2-flop synchroniser (2 cycles latency) before the receiver.
- Receiver: falling edge detected → wait CLKS_PER_BIT/2, re-sample; low = valid start, high = glitch (return idle). Then sample each data bit and stop bit every CLKS_PER_BIT. `byte_valid` pulses one cycle at stop-bit sample.
- `imem_we`, `imem_addr`, `imem_wdata` registered; asserted the cycle after the 4th byte's `byte_valid`, all three stable that cycle.
- DONE entered the same cycle the last `imem_we` is high; `cpu_reset` pulse and `cpu_hold` fall occur the following cycle.
- `start` and `byte_valid` in same cycle in DONE/ERR: `start` wins, byte discarded.
- `reset` mid-load: everything returns to reset values next cycle; partial image remains in memory, no further writes.

## Structure
- Shared package `loader_pkg`: FSM state encoding, header byte count (2), bytes-per-word (4).
- Sub-module `uart_rx` (synchroniser, bit timer, shift register, `byte_valid`/`byte_data`/`frame_err` outputs); parameter `CLKS_PER_BIT`.
- Top module holds FSM, byte/word counters, word assembly, output registers.

## Test plan
- CLK_FREQ=16, BAUD=1 (16 clk/bit): `start`, send 00 02 | 24 08 00 05 | 08 00 00 00 → writes addr 0 = 0x24080005, addr 1 = 0x08000000, each `imem_we` one cycle; `done`=1, single `cpu_reset` pulse, `cpu_hold` 0.
- Header 00 00 → `error`=1, no `imem_we`, `cpu_hold` stays 1; subsequent `start` + valid frame loads normally.
- Stop bit forced low on 3rd data byte → ERR, zero writes for that word, earlier words already written.
- 3-cycle low glitch on `rx` while idle → no `byte_valid`, FSM unchanged.
- `reset` asserted after 5 data bytes → all outputs at reset values next cycle, later bytes ignored.
- ADDR_W=2, header 00 04, 16 bytes → addresses 0..3 written, DONE; header 00 05 → ERR.

Source files
------------

// File: rtl/uart_program_loader_pkg.sv
// Shared definitions for the serial program loader: FSM encodings and frame geometry.
package loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR_HI,
    S_HDR_LO,
    S_DATA,
    S_DONE,
    S_ERR
  } load_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  localparam int HDR_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchroniser, mid-bit sampling, one-cycle byte_valid / frame_err.
module uart_rx
  import loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] FULL_CNT = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] HALF_CNT = TW'(CLKS_PER_BIT / 2 - 1);

  rx_state_t     state, state_n;
  logic [TW-1:0] timer, timer_n;
  logic [2:0]    bit_idx, bit_idx_n;
  logic [7:0]    shift, shift_n;
  logic          rx_meta, rx_sync, rx_prev;

  always_ff @(posedge clock) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
      state   <= RX_IDLE;
      timer   <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
      state   <= state_n;
      timer   <= timer_n;
      bit_idx <= bit_idx_n;
      shift   <= shift_n;
    end
  end

  // A start bit still low at its midpoint is genuine; anything shorter is a glitch.
  always_comb begin
    state_n    = state;
    timer_n    = timer + TW'(1);
    bit_idx_n  = bit_idx;
    shift_n    = shift;
    byte_valid = 1'b0;
    frame_err  = 1'b0;
    case (state)
      RX_IDLE: begin
        timer_n = '0;
        if (rx_prev && !rx_sync) state_n = RX_START;
      end
      RX_START: begin
        if (timer == HALF_CNT) begin
          timer_n   = '0;
          bit_idx_n = '0;
          state_n   = rx_sync ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (timer == FULL_CNT) begin
          timer_n   = '0;
          shift_n   = {rx_sync, shift[7:1]};
          bit_idx_n = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_n = RX_STOP;
        end
      end
      RX_STOP: begin
        if (timer == FULL_CNT) begin
          timer_n    = '0;
          state_n    = RX_IDLE;
          byte_valid = rx_sync;
          frame_err  = !rx_sync;
        end
      end
      default: state_n = RX_IDLE;
    endcase
  end

  assign byte_data = shift;

endmodule

// File: rtl/uart_program_loader.sv
// Boot loader: receives a length-prefixed big-endian word image over UART and writes it into
// instruction memory while holding the CPU, then releases the CPU with a one-cycle reset pulse.
module uart_program_loader
  import loader_pkg::*;
#(
  parameter int CLK_FREQ = 23_000_000,
  parameter int BAUD     = 128_000,
  parameter int ADDR_W   = 14
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              rx,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              cpu_reset,
  output logic              done,
  output logic              error
);

  localparam int          CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam logic [31:0] MAX_WORDS    = 32'd1 << ADDR_W;
  localparam int          HDR_W        = 8 * HDR_BYTES;
  localparam int          SR_W         = 8 * (BYTES_PER_WORD - 1);

  logic       rx_valid, rx_err;
  logic [7:0] rx_data;

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clock      (clock),
    .reset      (reset),
    .rx         (rx),
    .byte_valid (rx_valid),
    .byte_data  (rx_data),
    .frame_err  (rx_err)
  );

  load_state_t       state, state_n;
  logic [HDR_W-9:0]  hdr_hi, hdr_hi_n;
  logic [HDR_W-1:0]  n_words, n_words_n;
  logic [1:0]        byte_cnt, byte_cnt_n;
  logic [ADDR_W:0]   word_cnt, word_cnt_n;
  logic [SR_W-1:0]   word_sr, word_sr_n;
  logic              imem_we_n, cpu_hold_n, cpu_reset_n, done_n, error_n;
  logic [ADDR_W-1:0] imem_addr_n;
  logic [31:0]       imem_wdata_n;
  logic [HDR_W-1:0]  hdr_word;
  logic              hdr_ok, last_word;

  assign hdr_word  = {hdr_hi, rx_data};
  assign hdr_ok    = (hdr_word != '0) && (32'(hdr_word) <= MAX_WORDS);
  assign last_word = (32'(word_cnt) + 32'd1) == 32'(n_words);

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= S_IDLE;
      hdr_hi     <= '0;
      n_words    <= '0;
      byte_cnt   <= '0;
      word_cnt   <= '0;
      word_sr    <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      cpu_hold   <= 1'b0;
      cpu_reset  <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      state      <= state_n;
      hdr_hi     <= hdr_hi_n;
      n_words    <= n_words_n;
      byte_cnt   <= byte_cnt_n;
      word_cnt   <= word_cnt_n;
      word_sr    <= word_sr_n;
      imem_we    <= imem_we_n;
      imem_addr  <= imem_addr_n;
      imem_wdata <= imem_wdata_n;
      cpu_hold   <= cpu_hold_n;
      cpu_reset  <= cpu_reset_n;
      done       <= done_n;
      error      <= error_n;
    end
  end

  // cpu_hold still high in DONE marks the first DONE cycle, where the CPU gets released.
  always_comb begin
    state_n      = state;
    hdr_hi_n     = hdr_hi;
    n_words_n    = n_words;
    byte_cnt_n   = byte_cnt;
    word_cnt_n   = word_cnt;
    word_sr_n    = word_sr;
    imem_we_n    = 1'b0;
    imem_addr_n  = imem_addr;
    imem_wdata_n = imem_wdata;
    cpu_hold_n   = cpu_hold;
    cpu_reset_n  = 1'b0;
    done_n       = done;
    error_n      = error;
    case (state)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_n    = S_HDR_HI;
          done_n     = 1'b0;
          error_n    = 1'b0;
          byte_cnt_n = '0;
          word_cnt_n = '0;
          cpu_hold_n = 1'b1;
        end else if (state == S_DONE && cpu_hold) begin
          cpu_hold_n  = 1'b0;
          cpu_reset_n = 1'b1;
          done_n      = 1'b1;
        end
      end
      S_HDR_HI: begin
        if (rx_err) begin
          state_n = S_ERR;
          error_n = 1'b1;
        end else if (rx_valid) begin
          hdr_hi_n = rx_data;
          state_n  = S_HDR_LO;
        end
      end
      S_HDR_LO: begin
        if (rx_err || (rx_valid && !hdr_ok)) begin
          state_n = S_ERR;
          error_n = 1'b1;
        end else if (rx_valid) begin
          n_words_n = hdr_word;
          state_n   = S_DATA;
        end
      end
      S_DATA: begin
        if (rx_err) begin
          state_n = S_ERR;
          error_n = 1'b1;
        end else if (rx_valid) begin
          if (byte_cnt == 2'(BYTES_PER_WORD - 1)) begin
            imem_we_n    = 1'b1;
            imem_addr_n  = word_cnt[ADDR_W-1:0];
            imem_wdata_n = {word_sr, rx_data};
            word_cnt_n   = word_cnt + {{ADDR_W{1'b0}}, 1'b1};
            byte_cnt_n   = '0;
            if (last_word) state_n = S_DONE;
          end else begin
            word_sr_n  = {word_sr[SR_W-9:0], rx_data};
            byte_cnt_n = byte_cnt + 2'd1;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_program_loader.sv
// Scoreboard bench for uart_program_loader at 16 clocks per bit with a 2-bit address space.
module tb_uart_program_loader;

  localparam int ADDR_W = 2;
  localparam int BIT    = 16;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic              rx    = 1'b1;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_hold, cpu_reset, done, error;

  wr_t        exp_q[$];
  logic [7:0] tx_q[$];
  int         compared    = 0;
  int         mismatched  = 0;
  int         resets_seen = 0;

  uart_program_loader #(.CLK_FREQ(16), .BAUD(1), .ADDR_W(ADDR_W)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .rx         (rx),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_hold   (cpu_hold),
    .cpu_reset  (cpu_reset),
    .done       (done),
    .error      (error)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic expectWrite(input logic [ADDR_W-1:0] a, input logic [31:0] d);
    wr_t w;
    w.addr = a;
    w.data = d;
    exp_q.push_back(w);
  endtask

  task automatic sendByte(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    repeat (BIT) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BIT) @(negedge clock);
    end
    rx = stop_bit;
    repeat (BIT) @(negedge clock);
    rx = 1'b1;
    repeat (4) @(negedge clock);
  endtask

  task automatic applyStimulus();
    for (int i = 0; i < tx_q.size(); i++) sendByte(tx_q[i], 1'b1);
  endtask

  task automatic pulseStart();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_imem_we"},    32'(imem_we),    32'd0);
    checkOutput({tag, "_imem_addr"},  32'(imem_addr),  32'd0);
    checkOutput({tag, "_imem_wdata"}, imem_wdata,      32'd0);
    checkOutput({tag, "_cpu_hold"},   32'(cpu_hold),   32'd0);
    checkOutput({tag, "_cpu_reset"},  32'(cpu_reset),  32'd0);
    checkOutput({tag, "_done"},       32'(done),       32'd0);
    checkOutput({tag, "_error"},      32'(error),      32'd0);
  endtask

  // Monitor: every write strobe consumes one scoreboard entry; each cpu_reset sample counts as a pulse.
  always @(negedge clock) begin
    if (imem_we) begin
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL unexpected_write: got addr %0d data 0x%08h, expected no write at %0t",
                 imem_addr, imem_wdata, $time);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        checkOutput("write_addr", 32'(imem_addr), 32'(e.addr));
        checkOutput("write_data", imem_wdata, e.data);
      end
      checkOutput("hold_during_write", 32'(cpu_hold), 32'd1);
    end
    if (cpu_reset) begin
      resets_seen++;
      checkOutput("hold_at_cpu_reset", 32'(cpu_hold), 32'd0);
      checkOutput("done_at_cpu_reset", 32'(done), 32'd1);
    end
  end

  initial begin
    repeat (3) @(negedge clock);
    checkResetValues("reset");
    reset = 1'b0;
    @(negedge clock);

    // Short low glitch while idle must not start anything.
    rx = 1'b0;
    repeat (3) @(negedge clock);
    rx = 1'b1;
    repeat (40) @(negedge clock);
    checkOutput("glitch_hold", 32'(cpu_hold), 32'd0);
    checkOutput("glitch_error", 32'(error), 32'd0);
    checkOutput("glitch_done", 32'(done), 32'd0);

    // Two-word load.
    pulseStart();
    checkOutput("load1_hold_on_start", 32'(cpu_hold), 32'd1);
    expectWrite(2'd0, 32'h2408_0005);
    expectWrite(2'd1, 32'h0800_0000);
    tx_q = {8'h00, 8'h02, 8'h24, 8'h08, 8'h00, 8'h05, 8'h08, 8'h00, 8'h00, 8'h00};
    applyStimulus();
    repeat (4) @(negedge clock);
    checkOutput("load1_done", 32'(done), 32'd1);
    checkOutput("load1_error", 32'(error), 32'd0);
    checkOutput("load1_hold", 32'(cpu_hold), 32'd0);
    checkOutput("load1_pending", 32'(exp_q.size()), 32'd0);
    checkOutput("load1_resets", 32'(resets_seen), 32'd1);

    // Zero word count aborts, then a valid frame recovers.
    pulseStart();
    checkOutput("zero_done_cleared", 32'(done), 32'd0);
    tx_q = {8'h00, 8'h00};
    applyStimulus();
    checkOutput("zero_error", 32'(error), 32'd1);
    checkOutput("zero_hold", 32'(cpu_hold), 32'd1);
    checkOutput("zero_done", 32'(done), 32'd0);
    pulseStart();
    checkOutput("recover_error_cleared", 32'(error), 32'd0);
    expectWrite(2'd0, 32'hDEAD_BEEF);
    tx_q = {8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    applyStimulus();
    repeat (4) @(negedge clock);
    checkOutput("recover_done", 32'(done), 32'd1);
    checkOutput("recover_hold", 32'(cpu_hold), 32'd0);

    // Framing error on the third byte of the second word.
    pulseStart();
    expectWrite(2'd0, 32'h1122_3344);
    tx_q = {8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    applyStimulus();
    sendByte(8'h77, 1'b0);
    sendByte(8'h88, 1'b1);
    checkOutput("ferr_error", 32'(error), 32'd1);
    checkOutput("ferr_hold", 32'(cpu_hold), 32'd1);
    checkOutput("ferr_done", 32'(done), 32'd0);
    checkOutput("ferr_pending", 32'(exp_q.size()), 32'd0);

    // Reset after five data bytes; the rest of the frame is ignored.
    pulseStart();
    expectWrite(2'd0, 32'hA1A2_A3A4);
    tx_q = {8'h00, 8'h03, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hB1};
    applyStimulus();
    reset = 1'b1;
    @(negedge clock);
    checkResetValues("midreset");
    reset = 1'b0;
    tx_q = {8'hB2, 8'hB3, 8'hB4, 8'hC1, 8'hC2, 8'hC3, 8'hC4};
    applyStimulus();
    checkOutput("midreset_hold", 32'(cpu_hold), 32'd0);
    checkOutput("midreset_done", 32'(done), 32'd0);

    // Full address space: four words fit, five do not.
    pulseStart();
    expectWrite(2'd0, 32'h0102_0304);
    expectWrite(2'd1, 32'h1020_3040);
    expectWrite(2'd2, 32'hA55A_C33C);
    expectWrite(2'd3, 32'hFF00_FF01);
    tx_q = {8'h00, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'h10, 8'h20, 8'h30, 8'h40,
            8'hA5, 8'h5A, 8'hC3, 8'h3C, 8'hFF, 8'h00, 8'hFF, 8'h01};
    applyStimulus();
    repeat (4) @(negedge clock);
    checkOutput("full_done", 32'(done), 32'd1);
    checkOutput("full_error", 32'(error), 32'd0);
    pulseStart();
    tx_q = {8'h00, 8'h05, 8'h12, 8'h34, 8'h56, 8'h78};
    applyStimulus();
    checkOutput("over_error", 32'(error), 32'd1);
    checkOutput("over_done", 32'(done), 32'd0);
    checkOutput("over_hold", 32'(cpu_hold), 32'd1);

    repeat (4) @(negedge clock);
    checkOutput("final_pending", 32'(exp_q.size()), 32'd0);
    checkOutput("final_cpu_resets", 32'(resets_seen), 32'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
